// File: rtl/tank_gfx_pkg.sv
// Purpose: shared constants for the tank sprite pipeline: direction encoding and default sprite geometry/colour key.
// Latency: n/a (package).
// Backpressure: n/a (package).
package tank_gfx_pkg;

  typedef logic [1:0] dir_t;

  // ROM index order in four-ROM mode follows this encoding directly.
  localparam dir_t DIR_UP    = 2'd0;
  localparam dir_t DIR_DOWN  = 2'd1;
  localparam dir_t DIR_RIGHT = 2'd2;
  localparam dir_t DIR_LEFT  = 2'd3;

  localparam int          SPRITE_W_DEF    = 64;
  localparam int          SPRITE_H_DEF    = 64;
  localparam int          RGB_W_DEF       = 12;
  localparam logic [11:0] TRANSPARENT_DEF = 12'hF0F;

  // Mirror mode keeps only the UP and RIGHT images; the other two are address flips.
  function automatic int rom_count(input int mirror_mode);
    return (mirror_mode != 0) ? 2 : 4;
  endfunction

endpackage

// File: rtl/tank_sync_delay.sv
// Purpose: fixed-depth shift register used to delay-match timing, coordinates, background and flags.
// Latency: D cycles. Backpressure: none, advances every clock.
// Ports: clk, rst (sync, active-high, clears every stage), i_dat (W bits in), o_dat (W bits out, D cycles later).
module tank_sync_delay #(
  parameter int W = 1,
  parameter int D = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_dat,
  output logic [W-1:0] o_dat
);

  logic [W-1:0] r_pipe [D];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < D; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= i_dat;
      for (int i = 1; i < D; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_dat = r_pipe[D-1];

endmodule

// File: rtl/tank_sprite_fetch.sv
// Purpose: tank sprite overlay: frame-synced position latch, ROM address/select generation, colour-key composite.
// Latency: 2+ROM_LATENCY cycles from any input pixel to its output; all timing outputs match. Backpressure: none.
// Ports: VGA timing/coords + background rgb in, sprite pos/dir with i_pos_valid strobe, shared ROM address out,
//        packed ROM data in (ROM k at [k*RGB_W +: RGB_W]), delayed timing/coords, composited rgb, opaque-hit flag.
module tank_sprite_fetch
  import tank_gfx_pkg::*;
#(
  parameter int                 SPRITE_W    = SPRITE_W_DEF,
  parameter int                 SPRITE_H    = SPRITE_H_DEF,
  parameter int                 RGB_W       = RGB_W_DEF,
  parameter int                 CNT_W       = 11,
  parameter int                 ROM_LATENCY = 1,
  parameter int                 MIRROR_MODE = 0,
  parameter logic [RGB_W-1:0]   TRANSPARENT = TRANSPARENT_DEF,
  localparam int                ADDR_W      = $clog2(SPRITE_W * SPRITE_H),
  localparam int                N_ROM       = rom_count(MIRROR_MODE)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [CNT_W-1:0]       i_hcount_in,
  input  logic [CNT_W-1:0]       i_vcount_in,
  input  logic                   i_hsync_in,
  input  logic                   i_vsync_in,
  input  logic                   i_hblnk_in,
  input  logic                   i_vblnk_in,
  input  logic [RGB_W-1:0]       i_rgb_in,
  input  logic [CNT_W-1:0]       i_xpos,
  input  logic [CNT_W-1:0]       i_ypos,
  input  logic [1:0]             i_dir,
  input  logic                   i_pos_valid,
  output logic [ADDR_W-1:0]      o_rom_addr,
  input  logic [N_ROM*RGB_W-1:0] i_rom_data,
  output logic [CNT_W-1:0]       o_hcount_out,
  output logic [CNT_W-1:0]       o_vcount_out,
  output logic                   o_hsync_out,
  output logic                   o_vsync_out,
  output logic                   o_hblnk_out,
  output logic                   o_vblnk_out,
  output logic [RGB_W-1:0]       o_rgb_out,
  output logic                   o_sprite_hit
);

  localparam int XW    = $clog2(SPRITE_W);
  localparam int YW    = $clog2(SPRITE_H);
  localparam int SEL_W = (MIRROR_MODE != 0) ? 1 : 2;
  localparam int LAT   = 2 + ROM_LATENCY;
  localparam int TIM_W = 2 * CNT_W + 4;
  localparam logic [CNT_W:0] W_LIM = SPRITE_W[CNT_W:0];
  localparam logic [CNT_W:0] H_LIM = SPRITE_H[CNT_W:0];

  // Frame-sync position latch: pending follows every strobe, active only moves on the vblank rise.
  logic             r_vblnk_prev;
  logic [CNT_W-1:0] r_xpos_pend, r_ypos_pend, r_xpos_act, r_ypos_act;
  dir_t             r_dir_pend, r_dir_act;
  logic             w_vblnk_rise;

  assign w_vblnk_rise = i_vblnk_in & ~r_vblnk_prev;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vblnk_prev <= 1'b0;
      r_xpos_pend  <= '0;
      r_ypos_pend  <= '0;
      r_dir_pend   <= DIR_UP;
      r_xpos_act   <= '0;
      r_ypos_act   <= '0;
      r_dir_act    <= DIR_UP;
    end else begin
      r_vblnk_prev <= i_vblnk_in;
      if (i_pos_valid) begin
        r_xpos_pend <= i_xpos;
        r_ypos_pend <= i_ypos;
        r_dir_pend  <= i_dir;
      end
      if (w_vblnk_rise) begin
        // A strobe on the edge cycle bypasses pending so it is not a frame late.
        r_xpos_act <= i_pos_valid ? i_xpos : r_xpos_pend;
        r_ypos_act <= i_pos_valid ? i_ypos : r_ypos_pend;
        r_dir_act  <= i_pos_valid ? i_dir  : r_dir_pend;
      end
    end
  end

  // Stage A: one extra bit so pixels left of / above the sprite show up as negative.
  logic [CNT_W:0]  w_dx, w_dy;
  logic            w_inside;
  logic [XW-1:0]   w_dxp;
  logic [YW-1:0]   w_dyp;
  logic [SEL_W-1:0] w_sel;

  assign w_dx = {1'b0, i_hcount_in} - {1'b0, r_xpos_act};
  assign w_dy = {1'b0, i_vcount_in} - {1'b0, r_ypos_act};
  assign w_inside = ~w_dx[CNT_W] & (w_dx < W_LIM) & ~w_dy[CNT_W] & (w_dy < H_LIM)
                  & ~i_hblnk_in & ~i_vblnk_in;

  // Bitwise inversion of a power-of-two offset is SIZE-1-offset.
  assign w_dxp = (MIRROR_MODE != 0 && r_dir_act == DIR_LEFT) ? ~w_dx[XW-1:0] : w_dx[XW-1:0];
  assign w_dyp = (MIRROR_MODE != 0 && r_dir_act == DIR_DOWN) ? ~w_dy[YW-1:0] : w_dy[YW-1:0];
  // In mirror mode dir[1] splits UP/DOWN (ROM 0) from RIGHT/LEFT (ROM 1).
  assign w_sel = (MIRROR_MODE != 0) ? SEL_W'(r_dir_act[1]) : SEL_W'(r_dir_act);

  logic [ADDR_W-1:0] r_rom_addr;
  logic              r_inside;
  logic [SEL_W-1:0]  r_sel;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rom_addr <= '0;
      r_inside   <= 1'b0;
      r_sel      <= '0;
    end else begin
      r_rom_addr <= w_inside ? {w_dyp, w_dxp} : '0;
      r_inside   <= w_inside;
      r_sel      <= w_sel;
    end
  end

  assign o_rom_addr = r_rom_addr;

  // Stage B: flags ride alongside the ROM read; background waits one less than LAT for the output register.
  logic             w_inside_b;
  logic [SEL_W-1:0] w_sel_b;
  logic [RGB_W-1:0] w_rgb_b;
  logic [RGB_W-1:0] w_pix;

  tank_sync_delay #(.W(1 + SEL_W), .D(ROM_LATENCY)) u_flag_dly (
    .clk   (i_clk),
    .rst   (i_rst),
    .i_dat ({r_inside, r_sel}),
    .o_dat ({w_inside_b, w_sel_b})
  );

  tank_sync_delay #(.W(RGB_W), .D(LAT - 1)) u_rgb_dly (
    .clk   (i_clk),
    .rst   (i_rst),
    .i_dat (i_rgb_in),
    .o_dat (w_rgb_b)
  );

  tank_sync_delay #(.W(TIM_W), .D(LAT)) u_tim_dly (
    .clk   (i_clk),
    .rst   (i_rst),
    .i_dat ({i_hcount_in, i_vcount_in, i_hsync_in, i_vsync_in, i_hblnk_in, i_vblnk_in}),
    .o_dat ({o_hcount_out, o_vcount_out, o_hsync_out, o_vsync_out, o_hblnk_out, o_vblnk_out})
  );

  assign w_pix = i_rom_data[int'(w_sel_b) * RGB_W +: RGB_W];

  logic [RGB_W-1:0] r_rgb_out;
  logic             r_sprite_hit;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rgb_out    <= '0;
      r_sprite_hit <= 1'b0;
    end else if (w_inside_b && (w_pix != TRANSPARENT)) begin
      r_rgb_out    <= w_pix;
      r_sprite_hit <= 1'b1;
    end else begin
      r_rgb_out    <= w_rgb_b;
      r_sprite_hit <= 1'b0;
    end
  end

  assign o_rgb_out    = r_rgb_out;
  assign o_sprite_hit = r_sprite_hit;

endmodule

// File: tb/tb_tank_sprite_fetch.sv
// Purpose: scoreboard bench for three sprite-fetch builds (four-ROM, mirrored, ROM latency 3) on a shared input stream.
// Latency: expectations are queued at drive time and popped 3 (or 5) cycles later; ROM address checked after 1 cycle.
// Backpressure: none; every clock carries one pixel.
module tb_tank_sprite_fetch;
  import tank_gfx_pkg::*;

  localparam logic [11:0] KEY = 12'hF0F;

  typedef struct packed {
    logic [10:0] hc;
    logic [10:0] vc;
    logic        hs, vs, hb, vb;
    logic [11:0] rgb;
    logic        hit;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [10:0] hc_i, vc_i, xpos_i, ypos_i;
  logic        hs_i, vs_i, hb_i, vb_i, pv_i;
  logic [11:0] rgb_i;
  logic [1:0]  dir_i;
  int          rom_mode = 0;

  logic [10:0] hc_o [3];
  logic [10:0] vc_o [3];
  logic        hs_o [3];
  logic        vs_o [3];
  logic        hb_o [3];
  logic        vb_o [3];
  logic        hit_o [3];
  logic [11:0] rgb_o [3];
  logic [11:0] addr_o [3];
  logic [47:0] rd0, rd2;
  logic [23:0] rd1;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t        q0[$], q1[$], q2[$];
  logic [11:0] qa0[$], qa1[$], qa2[$];

  // Model of the frame latch.
  logic [10:0] m_xp, m_yp, m_xa, m_ya;
  logic [1:0]  m_dp, m_da;
  logic        m_vbp;

  // ROM contents: mode 0 is an address pattern distinct per ROM, modes 1/2 are the directed colour cases.
  function automatic logic [11:0] romf(input int k, input logic [11:0] a, input int mode);
    logic [11:0] kb;
    kb = 12'(k) << 10;
    case (mode)
      1:       return (k == 2) ? 12'h0A5 : 12'h000;
      2:       return (k == 2) ? KEY : 12'h000;
      default: return a ^ kb;
    endcase
  endfunction

  logic [11:0] p0, p1, p2a, p2b, p2c;
  always @(posedge clk) begin
    p0  <= addr_o[0];
    p1  <= addr_o[1];
    p2a <= addr_o[2];
    p2b <= p2a;
    p2c <= p2b;
  end
  assign rd0 = {romf(3, p0, rom_mode), romf(2, p0, rom_mode), romf(1, p0, rom_mode), romf(0, p0, rom_mode)};
  assign rd1 = {romf(1, p1, rom_mode), romf(0, p1, rom_mode)};
  assign rd2 = {romf(3, p2c, rom_mode), romf(2, p2c, rom_mode), romf(1, p2c, rom_mode), romf(0, p2c, rom_mode)};

  tank_sprite_fetch #(.ROM_LATENCY(1), .MIRROR_MODE(0)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_hcount_in(hc_i), .i_vcount_in(vc_i),
    .i_hsync_in(hs_i), .i_vsync_in(vs_i), .i_hblnk_in(hb_i), .i_vblnk_in(vb_i), .i_rgb_in(rgb_i),
    .i_xpos(xpos_i), .i_ypos(ypos_i), .i_dir(dir_i), .i_pos_valid(pv_i),
    .o_rom_addr(addr_o[0]), .i_rom_data(rd0),
    .o_hcount_out(hc_o[0]), .o_vcount_out(vc_o[0]), .o_hsync_out(hs_o[0]), .o_vsync_out(vs_o[0]),
    .o_hblnk_out(hb_o[0]), .o_vblnk_out(vb_o[0]), .o_rgb_out(rgb_o[0]), .o_sprite_hit(hit_o[0])
  );

  tank_sprite_fetch #(.ROM_LATENCY(1), .MIRROR_MODE(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_hcount_in(hc_i), .i_vcount_in(vc_i),
    .i_hsync_in(hs_i), .i_vsync_in(vs_i), .i_hblnk_in(hb_i), .i_vblnk_in(vb_i), .i_rgb_in(rgb_i),
    .i_xpos(xpos_i), .i_ypos(ypos_i), .i_dir(dir_i), .i_pos_valid(pv_i),
    .o_rom_addr(addr_o[1]), .i_rom_data(rd1),
    .o_hcount_out(hc_o[1]), .o_vcount_out(vc_o[1]), .o_hsync_out(hs_o[1]), .o_vsync_out(vs_o[1]),
    .o_hblnk_out(hb_o[1]), .o_vblnk_out(vb_o[1]), .o_rgb_out(rgb_o[1]), .o_sprite_hit(hit_o[1])
  );

  tank_sprite_fetch #(.ROM_LATENCY(3), .MIRROR_MODE(0)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_hcount_in(hc_i), .i_vcount_in(vc_i),
    .i_hsync_in(hs_i), .i_vsync_in(vs_i), .i_hblnk_in(hb_i), .i_vblnk_in(vb_i), .i_rgb_in(rgb_i),
    .i_xpos(xpos_i), .i_ypos(ypos_i), .i_dir(dir_i), .i_pos_valid(pv_i),
    .o_rom_addr(addr_o[2]), .i_rom_data(rd2),
    .o_hcount_out(hc_o[2]), .o_vcount_out(vc_o[2]), .o_hsync_out(hs_o[2]), .o_vsync_out(vs_o[2]),
    .o_hblnk_out(hb_o[2]), .o_vblnk_out(vb_o[2]), .o_rgb_out(rgb_o[2]), .o_sprite_hit(hit_o[2])
  );

  task automatic tb_check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic exp_t got_of(input int k);
    exp_t g;
    g.hc = hc_o[k]; g.vc = vc_o[k];
    g.hs = hs_o[k]; g.vs = vs_o[k]; g.hb = hb_o[k]; g.vb = vb_o[k];
    g.rgb = rgb_o[k]; g.hit = hit_o[k];
    return g;
  endfunction

  task automatic cmp_out(input string tag, input exp_t g, input exp_t e);
    tb_check({tag, ".rgb"}, 64'(g.rgb), 64'(e.rgb));
    tb_check({tag, ".hit"}, 64'(g.hit), 64'(e.hit));
    tb_check({tag, ".timing"}, 64'({g.hc, g.vc, g.hs, g.vs, g.hb, g.vb}),
             64'({e.hc, e.vc, e.hs, e.vs, e.hb, e.vb}));
  endtask

  task automatic calc(input bit mirror, output exp_t e, output logic [11:0] a);
    logic [11:0] dx, dy, pix;
    logic [5:0]  dxp, dyp;
    logic        ins;
    int          sel;
    dx  = {1'b0, hc_i} - {1'b0, m_xa};
    dy  = {1'b0, vc_i} - {1'b0, m_ya};
    ins = !dx[11] && dx < 12'd64 && !dy[11] && dy < 12'd64 && !hb_i && !vb_i;
    dxp = dx[5:0];
    dyp = dy[5:0];
    if (mirror && m_da == DIR_LEFT) dxp = 6'd63 - dxp;
    if (mirror && m_da == DIR_DOWN) dyp = 6'd63 - dyp;
    a   = ins ? {dyp, dxp} : 12'd0;
    if (mirror) sel = (m_da == DIR_RIGHT || m_da == DIR_LEFT) ? 1 : 0;
    else        sel = int'(m_da);
    pix = romf(sel, a, rom_mode);
    e.hc = hc_i; e.vc = vc_i; e.hs = hs_i; e.vs = vs_i; e.hb = hb_i; e.vb = vb_i;
    if (ins && pix != KEY) begin e.rgb = pix;   e.hit = 1'b1; end
    else                   begin e.rgb = rgb_i; e.hit = 1'b0; end
  endtask

  // One pixel clock: compare whatever has reached the outputs, then drive and queue the next pixel.
  task automatic cycle(input logic r, input logic [10:0] h, input logic [10:0] v, input logic hb,
                       input logic vb, input logic pv, input logic [10:0] x, input logic [10:0] y,
                       input logic [1:0] d);
    exp_t        e0, e1, z;
    logic [11:0] a0, a1;
    @(negedge clk);
    if (q0.size() == 3) cmp_out("dut0", got_of(0), q0.pop_front());
    if (q1.size() == 3) cmp_out("dut1", got_of(1), q1.pop_front());
    if (q2.size() == 5) cmp_out("dut2", got_of(2), q2.pop_front());
    if (qa0.size() != 0) tb_check("dut0.addr", 64'(addr_o[0]), 64'(qa0.pop_front()));
    if (qa1.size() != 0) tb_check("dut1.addr", 64'(addr_o[1]), 64'(qa1.pop_front()));
    if (qa2.size() != 0) tb_check("dut2.addr", 64'(addr_o[2]), 64'(qa2.pop_front()));
    rst = r; hc_i = h; vc_i = v; hb_i = hb; vb_i = vb; pv_i = pv;
    xpos_i = x; ypos_i = y; dir_i = d;
    rgb_i = 12'($urandom); hs_i = 1'($urandom); vs_i = 1'($urandom);
    if (r) begin
      // Reset discards everything in flight; those slots come out as zero.
      z = '0;
      foreach (q0[i]) q0[i] = z;
      foreach (q1[i]) q1[i] = z;
      foreach (q2[i]) q2[i] = z;
      q0.push_back(z); q1.push_back(z); q2.push_back(z);
      qa0.push_back(12'd0); qa1.push_back(12'd0); qa2.push_back(12'd0);
      m_xp = '0; m_yp = '0; m_dp = DIR_UP; m_xa = '0; m_ya = '0; m_da = DIR_UP; m_vbp = 1'b0;
    end else begin
      calc(1'b0, e0, a0);
      calc(1'b1, e1, a1);
      q0.push_back(e0); q1.push_back(e1); q2.push_back(e0);
      qa0.push_back(a0); qa1.push_back(a1); qa2.push_back(a0);
      if (vb && !m_vbp) begin
        if (pv) begin m_xa = x;    m_ya = y;    m_da = d;    end
        else    begin m_xa = m_xp; m_ya = m_yp; m_da = m_dp; end
      end
      if (pv) begin m_xp = x; m_yp = y; m_dp = d; end
      m_vbp = vb;
    end
  endtask

  task automatic pix(input int h, input int v);
    cycle(1'b0, 11'(h), 11'(v), 1'b0, 1'b0, 1'b0, 11'd0, 11'd0, DIR_UP);
  endtask

  task automatic flush();
    repeat (7) cycle(1'b0, 11'd0, 11'd0, 1'b1, 1'b0, 1'b0, 11'd0, 11'd0, DIR_UP);
  endtask

  // Vblank rise with a coincident strobe: the new position is active from the next cycle.
  task automatic set_pos(input int x, input int y, input logic [1:0] d);
    cycle(1'b0, 11'd0, 11'd0, 1'b1, 1'b0, 1'b0, 11'd0, 11'd0, DIR_UP);
    cycle(1'b0, 11'd0, 11'd0, 1'b1, 1'b1, 1'b1, 11'(x), 11'(y), d);
    cycle(1'b0, 11'd0, 11'd0, 1'b1, 1'b0, 1'b0, 11'd0, 11'd0, DIR_UP);
  endtask

  task automatic rand_pix(input int n, input int cx, input int cy);
    for (int i = 0; i < n; i++)
      cycle(1'b0, 11'(cx - 8 + $urandom_range(0, 80)), 11'(cy - 8 + $urandom_range(0, 80)),
            1'($urandom_range(0, 15) == 0), 1'b0, 1'b0, 11'd0, 11'd0, DIR_UP);
  endtask

  // Directed address check one cycle after the pixel was driven (four-ROM and mirrored builds).
  task automatic peek_addr(input string tag, input logic [11:0] e0, input logic [11:0] e1);
    @(posedge clk);
    #1;
    tb_check({tag, ".dut0"}, 64'(addr_o[0]), 64'(e0));
    tb_check({tag, ".dut1"}, 64'(addr_o[1]), 64'(e1));
  endtask

  initial begin
    repeat (4) cycle(1'b1, 11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 11'd0, 11'd0, DIR_UP);

    set_pos(100, 50, DIR_UP);
    pix(100, 50);  peek_addr("addr_origin", 12'd0, 12'd0);
    pix(163, 113); peek_addr("addr_corner", 12'd4095, 12'd4095);
    pix(164, 50);  peek_addr("addr_right_out", 12'd0, 12'd0);
    pix(99, 50); pix(100, 49); pix(100, 114);
    pix(115, 110);  // UP ROM holds the colour key at this offset
    cycle(1'b0, 11'd120, 11'd60, 1'b1, 1'b0, 1'b0, 11'd0, 11'd0, DIR_UP);
    rand_pix(150, 100, 50);

    set_pos(100, 50, DIR_DOWN);
    pix(100, 50); peek_addr("addr_down", 12'd0, 12'd4032);
    rand_pix(40, 100, 50);
    set_pos(100, 50, DIR_RIGHT);
    pix(100, 50); peek_addr("addr_right", 12'd0, 12'd0);
    rand_pix(40, 100, 50);
    set_pos(100, 50, DIR_LEFT);
    pix(100, 50); peek_addr("addr_left", 12'd0, 12'd63);
    rand_pix(40, 100, 50);

    flush(); rom_mode = 1;
    set_pos(100, 50, DIR_RIGHT);
    pix(110, 60); pix(90, 60); pix(130, 70);
    flush(); rom_mode = 2;
    pix(110, 60); pix(130, 70);
    flush(); rom_mode = 0;

    // Mid-frame strobes only touch pending; the last one before the vblank rise wins.
    cycle(1'b0, 11'd100, 11'd50, 1'b0, 1'b0, 1'b1, 11'd200, 11'd300, DIR_UP);
    pix(100, 50); pix(200, 300);
    cycle(1'b0, 11'd101, 11'd51, 1'b0, 1'b0, 1'b1, 11'd300, 11'd300, DIR_LEFT);
    cycle(1'b0, 11'd102, 11'd52, 1'b0, 1'b0, 1'b1, 11'd200, 11'd300, DIR_UP);
    pix(100, 50); pix(200, 300); pix(300, 300);
    cycle(1'b0, 11'd0, 11'd0, 1'b1, 1'b1, 1'b0, 11'd0, 11'd0, DIR_UP);
    cycle(1'b0, 11'd0, 11'd0, 1'b1, 1'b0, 1'b0, 11'd0, 11'd0, DIR_UP);
    pix(200, 300); pix(100, 50); pix(263, 363);
    rand_pix(40, 200, 300);
    // Edge strobe also refreshes pending, so a later plain rise keeps it.
    set_pos(50, 60, DIR_DOWN);
    cycle(1'b0, 11'd0, 11'd0, 1'b1, 1'b1, 1'b0, 11'd0, 11'd0, DIR_UP);
    cycle(1'b0, 11'd0, 11'd0, 1'b1, 1'b0, 1'b0, 11'd0, 11'd0, DIR_UP);
    pix(50, 60); pix(200, 300);
    rand_pix(30, 50, 60);

    // Reset mid-line, then the sprite sits at (0,0) facing UP.
    pix(60, 70); pix(61, 70);
    cycle(1'b1, 11'd62, 11'd70, 1'b0, 1'b0, 1'b0, 11'd0, 11'd0, DIR_UP);
    pix(0, 0); pix(10, 10); pix(63, 63); pix(64, 0); pix(0, 64);
    rand_pix(60, 8, 8);

    flush();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tank_sprite_fetch.md
Name: tank_sprite_fetch

Overview:
- Parametrised sprite pixel pipeline for the tank. Generalises the four-direction image bank.
- Takes the VGA timing stream and the tank position and direction, and generates the image ROM address.
- Selects the direction image, optionally mirroring a reduced ROM set. Applies a transparency key and overlays the tank on the incoming background.
- Sits between the background draw stage and the next layer. Timing outputs are delay-matched to the pixel output.

Parameters:
- SPRITE_W, 64, sprite width in pixels (power of 2).
- SPRITE_H, 64, sprite height in pixels (power of 2). ADDR_W = log2(SPRITE_W*SPRITE_H) = 12.
- RGB_W, 12, pixel colour width.
- CNT_W, 11, hcount/vcount/xpos/ypos width.
- ROM_LATENCY, 1, ROM read latency in clock cycles (1..3).
- MIRROR_MODE, 0, 0: four ROMs (up, down, right, left). 1: two ROMs (up, right); down and left come from address flipping.
- TRANSPARENT, 12'hF0F, colour key; ROM pixels equal to it are not drawn.

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous active-high reset
- hcount_in, vcount_in  in  CNT_W each  pixel coordinates
- hsync_in, vsync_in, hblnk_in, vblnk_in  in  1 each  timing
- rgb_in  in  RGB_W  background pixel
- xpos, ypos  in  CNT_W each  requested sprite top-left corner
- dir  in  2  requested direction (package encoding)
- pos_valid  in  1  strobe: capture xpos/ypos/dir into pending registers
- rom_addr  out  ADDR_W  shared address to all direction ROMs
- rom_data  in  N_ROM*RGB_W  packed ROM outputs, ROM k at bits [k*RGB_W +: RGB_W]; N_ROM = 4, or 2 if MIRROR_MODE
- hcount_out, vcount_out  out  CNT_W each  delayed coordinates
- hsync_out, vsync_out, hblnk_out, vblnk_out  out  1 each  delayed timing
- rgb_out  out  RGB_W  composited pixel
- sprite_hit  out  1  high when the output pixel is an opaque tank pixel (collision use)

Behaviour:
- Reset: every output 0. Pending and active pos = 0, dir = UP. Pipeline registers cleared. Reset mid-frame flushes in-flight pixels; output resumes correctly after LAT cycles.
- Frame-sync latch: pos_valid loads the pending registers; the last strobe in a frame wins.
  - On the vblnk_in rising edge (vblnk_in=1 while the registered previous value=0), active <= pending.
  - If pos_valid coincides with that edge, the new inputs go directly to active and to pending.
  - Active values never change outside that edge, so there is no tearing.
- Stage A (registered, cycle 1):
  - dx = hcount_in - xpos_act, dy = vcount_in - ypos_act, computed at CNT_W+1 bits.
  - inside = dx, dy non-negative, dx < SPRITE_W, dy < SPRITE_H, and no blanking. Sprites partly off-screen clip naturally.
- Mirroring (MIRROR_MODE=1):
  - DOWN uses the UP ROM with dy' = SPRITE_H-1-dy.
  - LEFT uses the RIGHT ROM with dx' = SPRITE_W-1-dx.
  - With MIRROR_MODE=0, dx' = dx and dy' = dy.
- Address: rom_addr = dy'*SPRITE_W + dx', a concatenation, registered at cycle 1. When not inside, rom_addr holds 0.
- ROM select: index = dir_act (4 ROMs). In mirror mode, UP/DOWN → 0 and RIGHT/LEFT → 1. The index is pipelined alongside the address.
- Stage B, cycle 1+ROM_LATENCY: data valid; select pix.
- Output register, cycle LAT = 2+ROM_LATENCY:
  - If inside and pix != TRANSPARENT: rgb_out = pix and sprite_hit = 1.
  - Else: rgb_out = delayed rgb_in and sprite_hit = 0.
- Timing and coordinate outputs are rgb_in-aligned inputs delayed by exactly LAT cycles (LAT=3 by default).
- dir values outside the encoding cannot occur (2 bits, full coverage).

Decomposition:
- Package tank_gfx_pkg:
  - DIR_UP=2'd0, DIR_DOWN=2'd1, DIR_RIGHT=2'd2, DIR_LEFT=2'd3. ROM index order matches this encoding.
  - Default SPRITE_W/H and TRANSPARENT constants.
- One sub-module, tank_sync_delay: parametrised width/depth shift register with synchronous reset. It delays timing, coordinates and rgb_in by LAT, and the inside/select flags by ROM_LATENCY.

Test Plan:
- Active pos (100,50), dir UP, four-ROM mode. At hcount=100, vcount=50: rom_addr=0 one cycle later. At (163,113): rom_addr=4095. At (164,50): inside=0 and rgb_out = rgb_in after 3 cycles.
- ROM2 returns 12'h0A5 and the others 12'h000, dir RIGHT, pixel inside: rgb_out=12'h0A5 and sprite_hit=1 at LAT=3. The same pixel with ROM2=12'hF0F gives background and sprite_hit=0.
- MIRROR_MODE=1, dir LEFT, pos (100,50), pixel (100,50): rom_addr=63 and ROM1 is selected. dir DOWN, pixel (100,50): rom_addr=63*64=4032, ROM0.
- pos_valid with (200,300) mid-frame: rendering stays at the old position until the vblnk_in rise, then the new position applies. A strobe on the exact edge cycle takes effect immediately.
- Assert rst for 1 cycle mid-line: all outputs 0 next cycle. After LAT cycles, outputs track the inputs again with active pos = (0,0) and dir UP.
- ROM_LATENCY=3: all outputs delayed exactly 5 cycles, and hsync_out aligned with rgb_out.
